// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS boot-and-run support logic.
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  localparam int DUMP_PAIRS = NUM_REGS / 2;
  localparam int DUMP_W     = $clog2(DUMP_PAIRS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP,
    DONE
  } loader_state_t;

endpackage

// File: rtl/up_counter.sv
// Free-running up counter with synchronous clear, enable and terminal-match flag.
module up_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] matchVal,
  output logic [WIDTH-1:0] count,
  output logic             atMatch
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign atMatch = (count == matchVal);

endmodule

// File: rtl/imem_loader.sv
// Boot sequencer: streams a program into instruction memory, runs the pipeline
// for a fixed budget, then walks the register-file read ports for a dump.
module imem_loader
  import mips_pkg::*;
#(
  parameter int MAX_WORDS = 32,
  parameter int IDX_W     = 5,
  parameter int RUN_W     = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [IDX_W:0]        progLength,
  input  logic [RUN_W-1:0]      runCycles,
  input  logic [INSTR_W-1:0]    wordIn,
  input  logic                  wordValid,
  output logic                  wordReady,
  output logic [INSTR_W-1:0]    instrIn,
  output logic [INSTR_W-1:0]    instrAddr,
  output logic                  instrWrite,
  output logic                  instrRead,
  output logic                  pcReset,
  output logic                  pcWrite,
  output logic                  initializing,
  output logic                  ending,
  output logic [REG_ADDR_W-1:0] endReadReg1,
  output logic [REG_ADDR_W-1:0] endReadReg2,
  output logic                  dumpValid,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = (IDX_W > DUMP_W) ? IDX_W : DUMP_W;

  loader_state_t    state, nextState;
  logic [IDX_W-1:0] lastIdx;
  logic [RUN_W-1:0] lastRun;
  logic             errorQ;
  logic             startOk, startAccept, startReject, loadDone;

  logic [CNT_W-1:0] idxCount, idxMatch;
  logic             idxAtMatch, idxClear, idxEnable;
  logic [RUN_W-1:0] runCountUnused;
  logic             runAtMatch, runClear;

  assign startOk = (progLength != '0) && (progLength <= (IDX_W+1)'(MAX_WORDS));

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState    = state;
    startAccept  = 1'b0;
    startReject  = 1'b0;
    loadDone     = 1'b0;
    wordReady    = 1'b0;
    initializing = 1'b0;
    pcReset      = 1'b0;
    pcWrite      = 1'b0;
    instrRead    = 1'b0;
    ending       = 1'b0;
    dumpValid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE, DONE: begin
        pcReset = 1'b1;
        done    = (state == DONE);
        if (start) begin
          if (startOk) begin
            startAccept = 1'b1;
            nextState   = LOAD;
          end else begin
            startReject = 1'b1;
            nextState   = IDLE;
          end
        end
      end
      LOAD: begin
        initializing = 1'b1;
        pcReset      = 1'b1;
        busy         = 1'b1;
        // Gated by resetN so a word offered on the reset edge is never written.
        wordReady    = resetN;
        if (wordValid && resetN && idxAtMatch) begin
          loadDone  = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        pcWrite   = 1'b1;
        instrRead = 1'b1;
        busy      = 1'b1;
        if (runAtMatch) nextState = DUMP;
      end
      DUMP: begin
        ending    = 1'b1;
        dumpValid = 1'b1;
        busy      = 1'b1;
        if (idxAtMatch) nextState = DONE;
      end
      default: nextState = IDLE;
    endcase
  end

  // runCycles of 0 is folded into a one-cycle budget when it is latched.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      errorQ  <= 1'b0;
      lastIdx <= '0;
      lastRun <= '0;
    end else if (startAccept) begin
      errorQ  <= 1'b0;
      lastIdx <= IDX_W'(progLength - (IDX_W+1)'(1));
      lastRun <= (runCycles == '0) ? '0 : runCycles - RUN_W'(1);
    end else if (startReject) begin
      errorQ  <= 1'b1;
    end
  end

  // One counter serves as the load word index and, later, the dump pair index.
  assign idxClear  = !resetN || !(state inside {LOAD, DUMP}) || loadDone;
  assign idxEnable = instrWrite || (state == DUMP);
  assign idxMatch  = (state == DUMP) ? CNT_W'(DUMP_PAIRS - 1) : CNT_W'(lastIdx);

  up_counter #(.WIDTH(CNT_W)) idxCounter (
    .clk      (clk),
    .clear    (idxClear),
    .enable   (idxEnable),
    .matchVal (idxMatch),
    .count    (idxCount),
    .atMatch  (idxAtMatch)
  );

  assign runClear = !resetN || (state != RUN) || runAtMatch;

  up_counter #(.WIDTH(RUN_W)) runCounter (
    .clk      (clk),
    .clear    (runClear),
    .enable   (state == RUN),
    .matchVal (lastRun),
    .count    (runCountUnused),
    .atMatch  (runAtMatch)
  );

  assign instrWrite  = wordReady & wordValid;
  assign instrIn     = (state == LOAD) ? wordIn : '0;
  assign instrAddr   = (state == LOAD) ? INSTR_W'({idxCount[IDX_W-1:0], 2'b00}) : '0;
  assign endReadReg1 = ending ? {idxCount[DUMP_W-1:0], 1'b0} : '0;
  assign endReadReg2 = ending ? {idxCount[DUMP_W-1:0], 1'b1} : REG_ADDR_W'(1);
  assign error       = errorQ;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-and-run sequencer that sits directly upstream of the MIPS pipeline. It accepts a program as a valid/ready word stream and writes the words into instruction memory at consecutive word addresses, holding PC in reset while it does so. It then releases the pipeline for a programmed number of cycles and finally freezes it. In that frozen state it steps the register file's two read ports through all 32 registers, two per cycle, for end-of-run inspection. It replaces the hand-coded load loop, fixed clock budget and register dump in the processor top.

## Interface
Parameters:
- MAX_WORDS, 32: instruction-memory capacity in words (power of two).
- IDX_W, 5: $clog2(MAX_WORDS).
- RUN_W, 16: width of the run-cycle budget.

Ports:
- clk  in  1  processor clock; all state changes on its rising edge.
- resetN  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- progLength  in  IDX_W+1  number of words to load; latched at start.
- runCycles  in  RUN_W  pipeline cycles to run after load; latched at start.
- wordIn  in  32  program word.
- wordValid  in  1  wordIn is valid.
- wordReady  out  1  loader accepts wordIn this cycle.
- instrIn  out  32  instruction-memory write data.
- instrAddr  out  32  instruction-memory byte address while initializing.
- instrWrite  out  1  instruction-memory write enable.
- instrRead  out  1  instruction-memory read enable.
- pcReset  out  1  holds PC at 0.
- pcWrite  out  1  PC load enable.
- initializing  out  1  selects instrAddr over PC at the instruction-memory address mux.
- ending  out  1  selects endReadReg1/2 at the register-file read-address muxes.
- endReadReg1, endReadReg2  out  5  dump read addresses.
- dumpValid  out  1  regData1/regData2 correspond to endReadReg1/2 this cycle.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  dump complete.
- error  out  1  rejected start; sticky until the next accepted start or reset.

## Operation
- States: IDLE, LOAD, RUN, DUMP, DONE.
- IDLE behaviour:
  - Outputs: pcReset=1, all other enables 0.
  - start with 1 ≤ progLength ≤ MAX_WORDS: latch progLength and runCycles, clear idx and error, go to LOAD.
  - start with any other progLength: set error=1 and stay in IDLE.
- LOAD behaviour:
  - Outputs: initializing=1, pcReset=1, wordReady=1.
  - Write path is combinational: instrWrite = wordValid & wordReady, instrIn = wordIn, instrAddr = {idx, 2'b00} zero-extended to 32 bits.
  - On acceptance, idx increments. When the word at idx = progLength-1 is accepted, go to RUN.
  - wordValid low inserts stall cycles; nothing is written during a stall.
- RUN behaviour:
  - Outputs: initializing=0, pcReset=0, pcWrite=1, instrRead=1. The run counter counts from 0.
  - When runCount = runCycles-1, go to DUMP.
  - runCycles=0 is treated as 1.
- DUMP behaviour:
  - Outputs: pcWrite=0, instrRead=0, ending=1, dumpValid=1, endReadReg1=2k, endReadReg2=2k+1, for k=0..15, one k per cycle.
  - PC holds its value; pcReset stays 0.
  - After k=15, go to DONE.
- DONE behaviour:
  - Outputs: done=1, ending=0, pcReset=1.
  - start behaves as in IDLE, except that a rejected start goes to IDLE with error=1.
- start outside IDLE/DONE is ignored. Words presented outside LOAD are not accepted (wordReady=0).

## Timing
- Reset values (all outputs registered or decoded from registered state): state IDLE, pcReset=1, every other 1-bit output 0, instrAddr=0, instrIn=0 (gated), endReadReg1=0, endReadReg2=1, idx=0, error=0.
- resetN low in any state returns to IDLE on that edge. A write in the same cycle is suppressed: instrWrite is gated by resetN.
- Cycle counts:
  - Start to first write opportunity: 1 cycle.
  - Unstalled load: progLength cycles.
  - RUN: max(runCycles,1) cycles.
  - DUMP: exactly 16 cycles.
- The first RUN cycle fetches from PC=0, because pcReset was 1 on the preceding edge.
- Simultaneous start and resetN low: reset wins.

## Structure
- Shared package mips_pkg holds:
  - the loader_state_t enum;
  - INSTR_W=32 and NUM_REGS=32;
  - the dump pair count NUM_REGS/2.
- One sub-module, up_counter (parameterised width, synchronous clear, enable, terminal-match output). It is instantiated twice: once for idx/k and once for the run counter.

## Test plan
- resetN low 2 cycles → pcReset=1, wordReady=0, instrWrite=0, done=0, endReadReg2=1.
- start, progLength=7, words 0x20110005…0x02304822 with no stalls → writes at addresses 0,4,…,24 in 7 consecutive cycles, then RUN with pcWrite=1.
- Same load with wordValid toggling every other cycle → exactly 7 writes, addresses contiguous, no duplicates.
- runCycles=12 → exactly 12 cycles with pcReset=0 and pcWrite=1, then 16 DUMP cycles with pairs (0,1)…(30,31), then done=1.
- start with progLength=0, then with MAX_WORDS+1 → error=1, state IDLE, no instrWrite.
- resetN low during the 3rd LOAD word and during DUMP k=5 → IDLE next cycle; no write on the reset cycle; ending=0.
